vga_stream_display: RTL and testbench

//  Avalon-ST sink for the 640x480 RGB pixel stream from the face/image sources; drives VGA pins.

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_st_fifo.sv | 55 +++++
 rtl/vga_stream_display.sv | 201 ++++++++++++++++++++
 tb/tb_vga_stream_display.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants and types for the VGA stream display.
// Defaults describe 640x480@60 on a 25.175 MHz pixel clock.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    SEEK,
    ARMED,
    STREAM
  } disp_state_t;

  typedef struct packed {
    logic        eop;
    logic        sop;
    logic [29:0] data;
  } st_beat_t;

endpackage

// File: rtl/vga_st_fifo.sv
// Show-ahead beat FIFO: head_o is valid whenever empty_o is low.
// Flush empties it in one cycle and overrides push/pop.
module vga_st_fifo
  import vga_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush_i,
  input  logic          push_i,
  input  st_beat_t      din_i,
  input  logic          pop_i,
  output st_beat_t      head_o,
  output logic [AW:0]   count_o,
  output logic          empty_o
);

  st_beat_t      mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i & (cnt_q != (AW+1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push & ~flush_i) begin
      mem_q[wr_q] <= din_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/vga_stream_display.sv
// Avalon-ST pixel sink driving VGA pins; raster free-runs and each
// frame is locked to startofpacket, any misalignment drops back to SEEK.
module vga_stream_display
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int FIFO_DEPTH = vga_pkg::FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] snk_data,
  input  logic        snk_startofpacket,
  input  logic        snk_endofpacket,
  input  logic        snk_valid,
  output logic        snk_ready,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hsync_n,
  output logic        vga_vsync_n,
  output logic        vga_blank_n,
  output logic        frame_locked,
  output logic        status_underrun,
  output logic        status_sync_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [HW-1:0] H_LPIX = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LPIX = VW'(V_ACTIVE - 1);

  logic [HW-1:0] h_q;
  logic [VW-1:0] v_q;
  disp_state_t   state_q, state_d;

  logic          active;
  logic          first_px;
  logic          last_px;
  logic          frame_end;
  logic          take;

  logic          push;
  logic          pop;
  logic          flush;
  logic          underrun;
  logic          sync_err;
  logic [29:0]   pix;
  st_beat_t      beat_in;
  st_beat_t      head;
  logic [AW:0]   count;
  logic          empty;
  logic          pad_unused;

  logic          hs_n_q;
  logic          vs_n_q;
  logic          blank_n_q;
  logic [7:0]    r_q;
  logic [7:0]    g_q;
  logic [7:0]    b_q;
  logic          ur_q;
  logic          se_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_LAST) begin
      h_q <= '0;
      v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  assign active    = (h_q < H_ACT) && (v_q < V_ACT);
  assign first_px  = (h_q == '0) && (v_q == '0);
  assign last_px   = (h_q == H_LPIX) && (v_q == V_LPIX);
  assign frame_end = (h_q == H_LAST) && (v_q == V_LAST);

  assign snk_ready = ~reset &
    ((state_q == SEEK) | (count < (AW+1)'(FIFO_DEPTH)));
  assign take      = snk_valid & snk_ready;
  assign beat_in   = '{eop:  snk_endofpacket,
                       sop:  snk_startofpacket,
                       data: snk_data};

  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    underrun = 1'b0;
    sync_err = 1'b0;
    pix      = '0;
    unique case (state_q)
      SEEK: begin
        if (take & snk_startofpacket) begin
          push    = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        push = take;
        if (frame_end) state_d = STREAM;
      end
      STREAM: begin
        push = take;
        if (active) begin
          if (empty) begin
            underrun = 1'b1;
          end else begin
            pop      = 1'b1;
            sync_err = (head.sop != first_px) |
                       (head.eop != last_px);
            if (!sync_err) pix = head.data;
          end
        end
        // A misaligned or missing beat discards the in-flight frame
        if (underrun | sync_err) begin
          flush   = 1'b1;
          push    = 1'b0;
          state_d = SEEK;
        end
      end
      default: state_d = SEEK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= SEEK;
    else       state_q <= state_d;
  end

  vga_st_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush),
    .push_i  (push),
    .din_i   (beat_in),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (count),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      ur_q      <= 1'b0;
      se_q      <= 1'b0;
    end else begin
      hs_n_q    <= ~((h_q >= HS_BEG) && (h_q < HS_END));
      vs_n_q    <= ~((v_q >= VS_BEG) && (v_q < VS_END));
      blank_n_q <= active;
      r_q       <= pix[29:22];
      g_q       <= pix[19:12];
      b_q       <= pix[9:2];
      ur_q      <= underrun;
      se_q      <= sync_err;
    end
  end

  assign pad_unused = ^{pix[21:20], pix[11:10], pix[1:0]};

  assign vga_hsync_n     = hs_n_q;
  assign vga_vsync_n     = vs_n_q;
  assign vga_blank_n     = blank_n_q;
  assign vga_r           = r_q;
  assign vga_g           = g_q;
  assign vga_b           = b_q;
  assign frame_locked    = (state_q == STREAM);
  assign status_underrun = ur_q;
  assign status_sync_err = se_q;

endmodule

// File: tb/tb_vga_stream_display.sv
// Randomized bench for vga_stream_display on a shrunken raster;
// a frame-level reference model feeds a scoreboard checked per cycle.
module tb_vga_stream_display;
  import vga_pkg::*;

  localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
  localparam int VA = 8, VFP = 1, VS = 2, VBP = 2;
  localparam int DEPTH = 16;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int NPIX = HA * VA;
  localparam int FRAME = HT * VT;
  localparam int M_SEEK = 0, M_ARMED = 1, M_STREAM = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [29:0] snk_data = '0;
  logic        sop = 1'b0, eop = 1'b0, valid = 1'b0;
  logic        snk_ready;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync_n, vga_vsync_n, vga_blank_n;
  logic        frame_locked, status_underrun, status_sync_err;

  always #5 clk = ~clk;

  vga_stream_display #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .snk_data          (snk_data),
    .snk_startofpacket (sop),
    .snk_endofpacket   (eop),
    .snk_valid         (valid),
    .snk_ready         (snk_ready),
    .vga_r             (vga_r),
    .vga_g             (vga_g),
    .vga_b             (vga_b),
    .vga_hsync_n       (vga_hsync_n),
    .vga_vsync_n       (vga_vsync_n),
    .vga_blank_n       (vga_blank_n),
    .frame_locked      (frame_locked),
    .status_underrun   (status_underrun),
    .status_sync_err   (status_sync_err)
  );

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       ur;
    logic       se;
    logic       lk;
  } exp_t;

  exp_t     exp_q[$];
  st_beat_t src_q[$];
  st_beat_t m_q[$];

  int tests = 0, fails = 0;
  int mstate = M_SEEK;
  int pos = 0;
  int sent = 0;
  int fcnt = 0;
  int vprob = 85;
  bit src_en = 1'b1;
  bit rst_next = 1'b1;
  bit meas = 1'b0;
  bit saw_bp = 1'b0;
  int hs_low = 0, vs_low = 0, bl_hi = 0;
  int ur_seen = 0, se_seen = 0;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [29:0] pix_data(int idx);
    logic [7:0] r, g, b;
    r = idx[7:0];
    g = 8'(idx * 3 + 7);
    b = 8'(255 - idx);
    return {r, 2'b01, g, 2'b10, b, 2'b11};
  endfunction

  task automatic queue_frame(int xsop, int xeop);
    st_beat_t bt;
    for (int i = 0; i < NPIX; i++) begin
      bt.data = pix_data(i + fcnt * 37);
      bt.sop  = (i == 0) || (i == xsop);
      bt.eop  = (i == NPIX - 1) || (i == xeop);
      src_q.push_back(bt);
    end
    fcnt++;
  endtask

  // Reference: raster position from elapsed cycles, frame lock from
  // SOP/EOP placement, beat buffer as a plain queue.
  task automatic model_cycle();
    exp_t     e;
    st_beat_t bt, in_bt;
    bit       rdy, acc, act, err;
    int       h, v, nxt;
    rdy = !reset && (mstate == M_SEEK || m_q.size() < DEPTH);
    check("ready", int'(snk_ready), int'(rdy));
    if (!reset && !snk_ready) saw_bp = 1'b1;
    acc = valid && rdy;
    in_bt = '{eop: eop, sop: sop, data: snk_data};
    if (acc) begin
      void'(src_q.pop_front());
      sent++;
    end
    e = '0;
    if (reset) begin
      e.hs = 1'b1;
      e.vs = 1'b1;
      mstate = M_SEEK;
      m_q.delete();
      pos = 0;
      exp_q.push_back(e);
      return;
    end
    h = pos % HT;
    v = pos / HT;
    act = (h < HA) && (v < VA);
    e.hs = !(h >= HA + HFP && h < HA + HFP + HS);
    e.vs = !(v >= VA + VFP && v < VA + VFP + VS);
    e.bl = act;
    err = 1'b0;
    nxt = mstate;
    if (mstate == M_STREAM && act) begin
      if (m_q.size() == 0) begin
        e.ur = 1'b1;
        err = 1'b1;
      end else begin
        bt = m_q.pop_front();
        if (bt.sop != (h == 0 && v == 0) ||
            bt.eop != (h == HA - 1 && v == VA - 1)) begin
          e.se = 1'b1;
          err = 1'b1;
        end else begin
          e.r = bt.data[29:22];
          e.g = bt.data[19:12];
          e.b = bt.data[9:2];
        end
      end
    end
    if (err) begin
      m_q.delete();
      nxt = M_SEEK;
    end else begin
      if (mstate == M_SEEK) begin
        if (acc && in_bt.sop) begin
          m_q.push_back(in_bt);
          nxt = M_ARMED;
        end
      end else if (acc) begin
        m_q.push_back(in_bt);
      end
      if (mstate == M_ARMED && pos == FRAME - 1) nxt = M_STREAM;
    end
    mstate = nxt;
    e.lk = (mstate == M_STREAM);
    pos = (pos + 1) % FRAME;
    exp_q.push_back(e);
  endtask

  task automatic step();
    st_beat_t bt;
    @(negedge clk);
    reset = rst_next;
    if (src_en && src_q.size() > 0 && $urandom_range(99) < vprob) begin
      bt = src_q[0];
      valid = 1'b1;
      sop = bt.sop;
      eop = bt.eop;
      snk_data = bt.data;
    end else begin
      valid = 1'b0;
      sop = 1'($urandom);
      eop = 1'($urandom);
      snk_data = 30'($urandom);
    end
    #1;
    if (meas) begin
      hs_low += int'(!vga_hsync_n);
      vs_low += int'(!vga_vsync_n);
      bl_hi  += int'(vga_blank_n);
    end
    model_cycle();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    int n = 0;
    while (src_q.size() > 0 && n < 20 * FRAME) begin
      step();
      n++;
    end
    check("drain_timeout", src_q.size(), 0);
    run(2 * FRAME);
  endtask

  always @(negedge clk) begin
    exp_t e, a;
    ur_seen += int'(status_underrun === 1'b1);
    se_seen += int'(status_sync_err === 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {vga_hsync_n, vga_vsync_n, vga_blank_n, vga_r, vga_g, vga_b,
           status_underrun, status_sync_err, frame_locked};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL pins @%0t: got %h expected %h", $time, a, e);
      end
    end
  end

  initial begin
    st_beat_t bt;
    int base, n;
    run(3);
    check("rst_ready", int'(snk_ready), 0);
    check("rst_hsync", int'(vga_hsync_n), 1);
    check("rst_rgb", int'({vga_r, vga_g, vga_b}), 0);
    rst_next = 1'b0;
    run(FRAME + 7);
    meas = 1'b1;
    run(FRAME);
    meas = 1'b0;
    check("hsync_low_per_frame", hs_low, HS * VT);
    check("vsync_low_per_frame", vs_low, VS * HT);
    check("blank_hi_per_frame", bl_hi, NPIX);

    for (int i = 0; i < 5; i++) begin
      bt.data = pix_data(200 + i);
      bt.sop = 1'b0;
      bt.eop = 1'b0;
      src_q.push_back(bt);
    end
    repeat (3) queue_frame(-1, -1);
    drain();

    vprob = 100;
    saw_bp = 1'b0;
    repeat (3) queue_frame(-1, -1);
    drain();
    check("backpressure_seen", int'(saw_bp), 1);

    vprob = 90;
    repeat (4) queue_frame(-1, -1);
    n = 0;
    while (mstate != M_STREAM && n < 5 * FRAME) begin
      step();
      n++;
    end
    check("lock_before_gap", mstate, M_STREAM);
    base = sent;
    n = 0;
    while (sent < base + 40 && n < 4 * FRAME) begin
      step();
      n++;
    end
    base = ur_seen;
    src_en = 1'b0;
    run(40);
    src_en = 1'b1;
    run(FRAME);
    check("gap_underrun_pulses", ur_seen - base, 1);
    drain();

    base = se_seen;
    queue_frame(-1, -1);
    queue_frame(10, -1);
    queue_frame(-1, -1);
    queue_frame(-1, 5);
    queue_frame(-1, -1);
    queue_frame(-1, -1);
    drain();
    check("sync_err_pulses", se_seen - base, 2);

    repeat (3) queue_frame(-1, -1);
    n = 0;
    while (mstate != M_STREAM && n < 5 * FRAME) begin
      step();
      n++;
    end
    run(50);
    rst_next = 1'b1;
    run(2);
    src_q.delete();
    rst_next = 1'b0;
    repeat (2) queue_frame(-1, -1);
    drain();

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
